// File: rtl/reindeer_fetch_mem_responder_pkg.sv
// Shared widths, state encoding and small address helpers for the fetch memory responder.
package reindeer_fetch_mem_responder_pkg;

    localparam int XLEN        = 32;
    localparam int PC_BITWIDTH = 32;

    localparam int S_IDLE_IDX    = 0;
    localparam int S_ISSUE_IDX   = 1;
    localparam int S_WAIT_IDX    = 2;
    localparam int S_CAPTURE_IDX = 3;

    typedef enum logic [3:0] {
        S_IDLE    = 4'(1 << S_IDLE_IDX),
        S_ISSUE   = 4'(1 << S_ISSUE_IDX),
        S_WAIT    = 4'(1 << S_WAIT_IDX),
        S_CAPTURE = 4'(1 << S_CAPTURE_IDX)
    } fetch_state_t;

    function automatic logic [PC_BITWIDTH-3:0] word_addr(input logic [PC_BITWIDTH-1:0] byte_addr);
        return byte_addr[PC_BITWIDTH-1:2];
    endfunction

endpackage

// File: rtl/reindeer_fetch_pending_buffer.sv
// One-entry request holder: a new push always replaces the held address, and a push wins over a pop.
module reindeer_fetch_pending_buffer
    import reindeer_fetch_mem_responder_pkg::*;
(
    input  logic                   clk,
    input  logic                   sync_reset,
    input  logic                   i_push,
    input  logic [PC_BITWIDTH-1:0] i_push_addr,
    input  logic                   i_pop,
    output logic                   o_valid,
    output logic [PC_BITWIDTH-1:0] o_addr
);

    logic                   r_valid;
    logic [PC_BITWIDTH-1:0] r_addr;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
        end else if (i_push) begin
            r_valid <= 1'b1;
            r_addr  <= i_push_addr;
        end else if (i_pop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_addr  = r_addr;

endmodule

// File: rtl/reindeer_fetch_mem_responder.sv
// Fetch-side SRAM responder: one read in flight, one redirect held pending.
// state     | meaning
// S_IDLE    | no access in flight
// S_ISSUE   | sram_ce high for the active word address
// S_WAIT    | counting extra SRAM read cycles
// S_CAPTURE | sram_rdata valid; registered into mem_data, done pulses next cycle
module reindeer_fetch_mem_responder
    import reindeer_fetch_mem_responder_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic                   clk,
    input  logic                   sync_reset,
    input  logic                   read_mem_enable,
    input  logic [PC_BITWIDTH-1:0] read_mem_addr,
    output logic                   mem_read_done,
    output logic [XLEN-1:0]        mem_data,
    output logic                   mem_fetch_misaligned,
    output logic                   sram_ce,
    output logic [PC_BITWIDTH-3:0] sram_addr,
    input  logic [XLEN-1:0]        sram_rdata
);

    localparam int           WAIT_LOAD_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [2:0]   WAIT_LOAD   = WAIT_LOAD_I[2:0];

    fetch_state_t            r_state;
    logic [2:0]              r_wait_cnt;
    logic [1:0]              r_active_lsb;
    logic                    r_ce;
    logic [PC_BITWIDTH-3:0]  r_sram_addr;
    logic                    r_done;
    logic                    r_misaligned;
    logic [XLEN-1:0]         r_data;

    logic                    w_pend_valid;
    logic [PC_BITWIDTH-1:0]  w_pend_addr;
    logic                    w_push;
    logic                    w_pop;

    // A request in the capture cycle only bypasses the buffer when nothing is already waiting.
    assign w_push = read_mem_enable &&
                    ((r_state == S_ISSUE) || (r_state == S_WAIT) ||
                     ((r_state == S_CAPTURE) && w_pend_valid));
    assign w_pop  = (r_state == S_CAPTURE) && w_pend_valid;

    reindeer_fetch_pending_buffer u_pending (
        .clk         (clk),
        .sync_reset  (sync_reset),
        .i_push      (w_push),
        .i_push_addr (read_mem_addr),
        .i_pop       (w_pop),
        .o_valid     (w_pend_valid),
        .o_addr      (w_pend_addr)
    );

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= '0;
            r_active_lsb <= '0;
            r_ce         <= 1'b0;
            r_sram_addr  <= '0;
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
            r_data       <= '0;
        end else begin
            r_ce         <= 1'b0;
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (read_mem_enable) begin
                        r_active_lsb <= read_mem_addr[1:0];
                        r_sram_addr  <= word_addr(read_mem_addr);
                        r_ce         <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (WAIT_STATES > 0) begin
                        r_wait_cnt <= WAIT_LOAD;
                        r_state    <= S_WAIT;
                    end else begin
                        r_state    <= S_CAPTURE;
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == 3'd0) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 3'd1;
                    end
                end
                S_CAPTURE: begin
                    r_data       <= sram_rdata;
                    r_done       <= 1'b1;
                    r_misaligned <= |r_active_lsb;
                    if (w_pend_valid) begin
                        r_active_lsb <= w_pend_addr[1:0];
                        r_sram_addr  <= word_addr(w_pend_addr);
                        r_ce         <= 1'b1;
                        r_state      <= S_ISSUE;
                    end else if (read_mem_enable) begin
                        r_active_lsb <= read_mem_addr[1:0];
                        r_sram_addr  <= word_addr(read_mem_addr);
                        r_ce         <= 1'b1;
                        r_state      <= S_ISSUE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_read_done        = r_done;
    assign mem_fetch_misaligned = r_misaligned;
    assign mem_data             = r_data;
    assign sram_ce              = r_ce;
    assign sram_addr            = r_sram_addr;

endmodule
